// File: rtl/bcd_pkg.sv
// Shared types and constants for the cascaded BCD counter.
//   bcd_digit_t : one packed BCD digit
//   BCD_MAX     : largest value of a non-top digit
//   lap_state_t : lap display state machine encoding
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic {
    RUNNING = 1'b0,
    FROZEN  = 1'b1
  } lap_state_t;

  // Clamp a loaded digit to the digit's legal maximum.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d, input bcd_digit_t max_v);
    return (d > max_v) ? max_v : d;
  endfunction

endpackage

// File: rtl/bcd_chain_counter_digit.sv
// One BCD digit with wrap at MAX (up) / wrap to MAX (down).
// Ports:
//   clock, nRST   : rising-edge clock, synchronous active-low reset
//   clear         : synchronous clear to 0
//   load          : load the clamped load_digit
//   load_digit    : digit value to load
//   step          : advance this digit one place in the up_down direction
//   up_down       : 1 = up, 0 = down
//   value         : registered digit value
//   at_max/at_zero: digit sits at MAX / at 0 (feeds the carry/borrow chain)
module bcd_digit
  import bcd_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic       clock,
  input  logic       nRST,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step,
  input  logic       up_down,
  output logic [3:0] value,
  output logic       at_max,
  output logic       at_zero
);

  localparam bcd_digit_t MAX_D = bcd_digit_t'(MAX);

  bcd_digit_t r_value;

  always_ff @(posedge clock) begin
    if (!nRST) begin
      r_value <= '0;
    end else if (clear) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= bcd_clamp(load_digit, MAX_D);
    end else if (step) begin
      if (up_down) r_value <= (r_value == MAX_D) ? 4'd0 : r_value + 4'd1;
      else         r_value <= (r_value == 4'd0) ? MAX_D : r_value - 4'd1;
    end
  end

  assign value   = r_value;
  assign at_max  = (r_value == MAX_D);
  assign at_zero = (r_value == 4'd0);

endmodule

// File: rtl/bcd_chain_counter.sv
// N-digit cascaded BCD counter with up/down, parallel load, lap freeze and
// a registered rollover pulse.
// Ports:
//   clock, nRST : rising-edge clock, synchronous active-low reset
//   count_tick  : one-cycle count pulse, gated by enable
//   clear       : synchronous clear of count, lap state and rollover
//   up_down     : 1 = up, 0 = down
//   load        : parallel load strobe, load_value digit 0 in [3:0]
//   lap         : one-cycle lap toggle pulse
//   live_count  : running count
//   number      : lap snapshot while frozen, else live_count
//   frozen      : lap snapshot displayed (lap FSM state == FROZEN)
//   rollover    : one-cycle pulse after a wrapping edge
// Handshake: none; every strobe is a single-cycle level sampled on the edge,
// priority nRST > clear > load > qualified tick, one action per edge.
module bcd_chain_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int TOP_DIGIT_MAX = 9
) (
  input  logic                    clock,
  input  logic                    nRST,
  input  logic                    count_tick,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] live_count,
  output logic [4*NUM_DIGITS-1:0] number,
  output logic                    frozen,
  output logic                    rollover
);

  logic [NUM_DIGITS-1:0]   w_at_max;
  logic [NUM_DIGITS-1:0]   w_at_zero;
  logic [NUM_DIGITS:0]     w_up_chain;
  logic [NUM_DIGITS:0]     w_dn_chain;
  logic                    w_tick;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] w_count;
  logic [4*NUM_DIGITS-1:0] r_lap;
  lap_state_t              r_lap_state;
  logic                    r_rollover;

  // Clear and load take the edge, so a coincident tick is dropped.
  assign w_tick = count_tick & enable & ~clear & ~load;

  // Chain bit i: all digits below i are at max (up) / at zero (down).
  always_comb begin
    w_up_chain    = '0;
    w_dn_chain    = '0;
    w_up_chain[0] = 1'b1;
    w_dn_chain[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_up_chain[i+1] = w_up_chain[i] & w_at_max[i];
      w_dn_chain[i+1] = w_dn_chain[i] & w_at_zero[i];
    end
  end

  assign w_wrap = w_tick & (up_down ? w_up_chain[NUM_DIGITS] : w_dn_chain[NUM_DIGITS]);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic w_step;
    assign w_step = w_tick & (up_down ? w_up_chain[g] : w_dn_chain[g]);

    bcd_digit #(
      .MAX ((g == NUM_DIGITS - 1) ? TOP_DIGIT_MAX : 9)
    ) u_digit (
      .clock      (clock),
      .nRST       (nRST),
      .clear      (clear),
      .load       (load),
      .load_digit (load_value[4*g +: 4]),
      .step       (w_step),
      .up_down    (up_down),
      .value      (w_count[4*g +: 4]),
      .at_max     (w_at_max[g]),
      .at_zero    (w_at_zero[g])
    );
  end

  always_ff @(posedge clock) begin
    if (!nRST || clear) r_rollover <= 1'b0;
    else                r_rollover <= w_wrap;
  end

  // Lap FSM: the snapshot is the pre-edge live count, so a coincident tick
  // is not captured.
  always_ff @(posedge clock) begin
    if (!nRST || clear) begin
      r_lap_state <= RUNNING;
      r_lap       <= '0;
    end else if (lap) begin
      case (r_lap_state)
        RUNNING: begin
          r_lap       <= w_count;
          r_lap_state <= FROZEN;
        end
        default: r_lap_state <= RUNNING;
      endcase
    end
  end

  assign live_count = w_count;
  assign frozen     = (r_lap_state == FROZEN);
  assign number     = frozen ? r_lap : w_count;
  assign rollover   = r_rollover;

endmodule

// File: tb/tb_bcd_chain_counter.sv
module tb_bcd_chain_counter;

  logic       clock = 1'b0;
  logic       nRST, count_tick, enable, clear, up_down, load, lap;
  logic [7:0] load_value;
  logic [7:0] live_a, number_a, live_b, number_b;
  logic       frozen_a, rollover_a, frozen_b, rollover_b;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clock = ~clock;

  // a: 2 digits, top max 9; b: 2 digits, top max 5. Shared stimulus.
  bcd_chain_counter #(.NUM_DIGITS(2), .TOP_DIGIT_MAX(9)) u_dut_a (
    .clock(clock), .nRST(nRST), .count_tick(count_tick), .enable(enable),
    .clear(clear), .up_down(up_down), .load(load), .load_value(load_value),
    .lap(lap), .live_count(live_a), .number(number_a), .frozen(frozen_a),
    .rollover(rollover_a)
  );

  bcd_chain_counter #(.NUM_DIGITS(2), .TOP_DIGIT_MAX(5)) u_dut_b (
    .clock(clock), .nRST(nRST), .count_tick(count_tick), .enable(enable),
    .clear(clear), .up_down(up_down), .load(load), .load_value(load_value),
    .lap(lap), .live_count(live_b), .number(number_b), .frozen(frozen_b),
    .rollover(rollover_b)
  );

  // Apply one edge's inputs at the falling edge, sample 1ns after rising edge.
  task automatic drive(input logic rst_n, input logic clr, input logic ld,
                       input logic [7:0] lv, input logic lp, input logic tk,
                       input logic ud);
    @(negedge clock);
    nRST = rst_n; clear = clr; load = ld; load_value = lv;
    lap = lp; count_tick = tk; up_down = ud;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick(input logic ud);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, ud);
  endtask

  task automatic do_load(input logic [7:0] v);
    drive(1'b1, 1'b0, 1'b1, v, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_lap();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; count_tick = 1'b0; enable = 1'b1; clear = 1'b0;
    up_down = 1'b1; load = 1'b0; lap = 1'b0; load_value = 8'h00;

    // Reset
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_live", live_a, 8'h00);
    chk("rst_number", number_a, 8'h00);
    chk("rst_frozen", {7'd0, frozen_a}, 8'h00);
    chk("rst_rollover", {7'd0, rollover_a}, 8'h00);

    // Up count through wrap
    do_load(8'h98);
    chk("load_98", live_a, 8'h98);
    chk("load_98_roll", {7'd0, rollover_a}, 8'h00);
    tick(1'b1);
    chk("up_99", live_a, 8'h99);
    chk("up_99_number", number_a, 8'h99);
    tick(1'b1);
    chk("up_wrap_00", live_a, 8'h00);
    chk("up_wrap_roll", {7'd0, rollover_a}, 8'h01);
    idle();
    chk("roll_one_cycle", {7'd0, rollover_a}, 8'h00);
    chk("idle_hold", live_a, 8'h00);

    // Down count through wrap and borrow
    tick(1'b0);
    chk("dn_wrap_99", live_a, 8'h99);
    chk("dn_wrap_roll", {7'd0, rollover_a}, 8'h01);
    tick(1'b0);
    chk("dn_98", live_a, 8'h98);
    chk("dn_98_roll", {7'd0, rollover_a}, 8'h00);
    do_load(8'h10);
    tick(1'b0);
    chk("dn_borrow_09", live_a, 8'h09);

    // Load clamping, top max 5 variant
    do_load(8'hAF);
    chk("clamp_AF_a", live_a, 8'h99);
    chk("clamp_AF_b", live_b, 8'h59);
    do_load(8'h7C);
    chk("clamp_7C_a", live_a, 8'h79);
    chk("clamp_7C_b", live_b, 8'h59);
    chk("load_no_roll_b", {7'd0, rollover_b}, 8'h00);
    tick(1'b1);
    chk("top5_wrap_b", live_b, 8'h00);
    chk("top5_roll_b", {7'd0, rollover_b}, 8'h01);
    chk("top5_carry_a", live_a, 8'h80);
    chk("top5_noroll_a", {7'd0, rollover_a}, 8'h00);

    // Lap freeze while counting continues
    do_load(8'h12);
    do_lap();
    chk("lap_frozen", {7'd0, frozen_a}, 8'h01);
    chk("lap_number", number_a, 8'h12);
    for (int i = 0; i < 5; i++) tick(1'b1);
    chk("lap_live_17", live_a, 8'h17);
    chk("lap_hold_12", number_a, 8'h12);
    chk("lap_still_frozen", {7'd0, frozen_a}, 8'h01);
    do_lap();
    chk("unlap_frozen", {7'd0, frozen_a}, 8'h00);
    chk("unlap_number", number_a, 8'h17);

    // Lap coincident with a tick captures the pre-tick value
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("laptick_live", live_a, 8'h18);
    chk("laptick_number", number_a, 8'h17);
    // Load leaves lap state alone
    do_load(8'h45);
    chk("load_frozen_keep", {7'd0, frozen_a}, 8'h01);
    chk("load_frozen_num", number_a, 8'h17);
    chk("load_frozen_live", live_a, 8'h45);

    // Clear with tick while frozen
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("clr_live", live_a, 8'h00);
    chk("clr_number", number_a, 8'h00);
    chk("clr_frozen", {7'd0, frozen_a}, 8'h00);
    chk("clr_roll", {7'd0, rollover_a}, 8'h00);

    // Load with tick at max: tick dropped, no rollover
    drive(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
    chk("loadtick_live", live_a, 8'h99);
    chk("loadtick_roll", {7'd0, rollover_a}, 8'h00);

    // Clear with a wrapping tick suppresses rollover
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("clrwrap_roll", {7'd0, rollover_a}, 8'h00);
    chk("clrwrap_live", live_a, 8'h00);

    // Down wrap on the top-max-5 variant
    tick(1'b0);
    chk("dn_wrap_b", live_b, 8'h59);
    chk("dn_wrap_roll_b", {7'd0, rollover_b}, 8'h01);

    // Reset mid-count
    do_load(8'h33);
    do_lap();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("rst_mid_live", live_a, 8'h00);
    chk("rst_mid_number", number_a, 8'h00);
    chk("rst_mid_frozen", {7'd0, frozen_a}, 8'h00);
    chk("rst_mid_roll", {7'd0, rollover_a}, 8'h00);

    // Enable low: ticks ignored, lap still works
    do_load(8'h27);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1);
    chk("en_low_hold", live_a, 8'h27);
    do_lap();
    chk("en_low_lap", {7'd0, frozen_a}, 8'h01);
    tick(1'b0);
    chk("en_low_hold_dn", live_a, 8'h27);
    chk("en_low_number", number_a, 8'h27);
    enable = 1'b1;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_chain_counter.md
Name: bcd_chain_counter

Overview:
- Parametrised successor to the two-digit stopwatch BCD counter: an N-digit cascaded BCD counter with up/down mode, parallel load, lap freeze and a rollover pulse.
- Sits between the timer's once-per-second tick pulse and the display driver; feeds seven-segment decode directly.
- The top digit has a configurable maximum, so the same block serves 00-99 seconds, 0-5 tens-of-minutes, etc.

Parameters:
- NUM_DIGITS, 2, number of cascaded BCD digits (1..8).
- TOP_DIGIT_MAX, 9, maximum value of the most-significant digit (1..9); lower digits always run 0..9.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- nRST  input  1  synchronous, active-low reset.
- count_tick  input  1  single-cycle count pulse (one per second from timer).
- enable  input  1  count gate; ticks ignored when low.
- clear  input  1  synchronous clear of count and lap state.
- up_down  input  1  1 = count up, 0 = count down; sampled with each tick.
- load  input  1  parallel load strobe.
- load_value  input  4*NUM_DIGITS  BCD value to load, digit 0 in [3:0].
- lap  input  1  single-cycle lap toggle pulse.
- live_count  output  4*NUM_DIGITS  registered running count.
- number  output  4*NUM_DIGITS  display value: lap snapshot when frozen, else live_count.
- frozen  output  1  high while lap snapshot is displayed.
- rollover  output  1  one-cycle pulse on wrap in either direction.

Behaviour:
- Reset: synchronous; when nRST low at rising edge: live_count=0, lap register=0, frozen=0, rollover=0. Overrides all other inputs.
- Count-update priority per edge: nRST > clear > load > (count_tick & enable). Only one action per cycle.
- Latency: live_count changes on the edge that samples the action; number follows combinationally from registers (same cycle as live_count when not frozen).
- Up count: digit 0 increments on a qualified tick. Digit i>0 increments when all lower digits are 9 (ripple carry is combinational, single cycle). Lower digit 9->0. Top digit TOP_DIGIT_MAX->0.
- Up wrap: all digits at max (top=TOP_DIGIT_MAX, others 9) + tick -> all 0, rollover=1 for that cycle.
- Down count: digit 0 decrements. Digit i>0 decrements when all lower digits are 0. Lower digit 0->9. Top digit 0->TOP_DIGIT_MAX.
- Down wrap: all 0 + tick -> max value, rollover=1.
- Load: each lower digit >9 is clamped to 9; top digit >TOP_DIGIT_MAX is clamped to TOP_DIGIT_MAX. Load never asserts rollover.
- Load, clear and reset in the same cycle as a tick: the tick is dropped.
- rollover is registered: high exactly the cycle after the wrapping edge, low otherwise; also cleared by clear.
- Lap state machine, states RUNNING and FROZEN:
  - RUNNING + lap: lap register <= live_count value before this edge's update; go to FROZEN.
  - FROZEN + lap: go to RUNNING.
  - clear or reset: RUNNING and lap register = 0.
  - load does not change lap state.
  - Counting continues while FROZEN; number shows the snapshot, live_count keeps advancing.
- lap coinciding with a tick: the snapshot takes the pre-tick value.
- enable low: count holds; lap and load still function.

Decomposition:
- Shared package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - constant BCD_MAX = 4'd9.
  - enum lap_state_t {RUNNING, FROZEN}.
- Sub-module bcd_digit, instantiated NUM_DIGITS times via generate.
  - Parameter MAX.
  - Inputs: clock, nRST, clear, load, load_digit, step, up_down.
  - Outputs: value, at_max, at_zero.
- Top level holds the carry/borrow chain, lap FSM and rollover register.

Test Plan:
- NUM_DIGITS=2, TOP_DIGIT_MAX=9, up: load 0x98 then 2 ticks -> live_count 0x99, then 0x00 with rollover high for exactly one cycle.
- Down from 0x00, 1 tick -> 0x99, rollover pulse. Next tick -> 0x98. Down from 0x10 -> 0x09.
- Load 0xAF -> live_count 0x99 (lower digit clamped). With TOP_DIGIT_MAX=5, load 0x7C -> 0x59 and up-tick -> 0x00 with rollover.
- Lap at 0x12, then 5 ticks -> number=0x12, live_count=0x17, frozen=1. Second lap -> number=0x17, frozen=0.
- clear together with count_tick at 0x45 while FROZEN -> live_count 0x00, number 0x00, frozen 0, no rollover.
- nRST low mid-count at 0x33 with enable=1 and tick=1 -> all outputs 0 next edge. enable=0 with 3 ticks -> count unchanged.
